// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: shared response codes, register kinds and helpers for the register bank
package axil_regbank_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {REG_RW, REG_RO, REG_SHADOW} reg_kind_e;
  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic logic [63:0] apply_wstrb(input logic [63:0] old, input logic [63:0] wdata, input logic [7:0] wstrb);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction
  function automatic reg_kind_e reg_kind(input logic ro, input logic sh);
    return ro ? REG_RO : (sh ? REG_SHADOW : REG_RW);
  endfunction
endpackage

// File: rtl/axil_regbank_if.sv
// axil_regbank_if: AXI4-Lite bus bundle between the PS master and the register bank
interface axil_regbank_if #(parameter int AW = 6, parameter int DW = 32);
  logic awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0] awprot;
  logic wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0] arprot;
  logic rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_regbank_skid.sv
// axil_regbank_skid: single-entry skid buffer with combinational pass-through, ready high while empty
module axil_regbank_skid #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign o_ready = !valid_q;
  assign o_valid = i_valid || valid_q;
  assign o_data = valid_q ? data_q : i_data;
  // park the offered beat when the consumer stalls, release it once drained
  always_comb begin
    valid_d = o_valid && !i_ready;
    data_d = valid_q ? data_q : i_data;
  end
  // skid storage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with plain, read-only and frame-committed shadow registers
module axil_regbank import axil_regbank_pkg::*; #(
  parameter int C_AXI_ADDR_WIDTH = 6,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int N_REGS = 8,
  parameter logic [N_REGS*C_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [N_REGS-1:0] RO_MASK = '0,
  parameter logic [N_REGS-1:0] SHADOW_MASK = '0,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 i_reset,
  axil_regbank_if.slave                        s_axi,
  output logic [N_REGS*C_AXI_DATA_WIDTH-1:0]   o_ctrl,
  input  logic [N_REGS*C_AXI_DATA_WIDTH-1:0]   i_status,
  output logic [N_REGS-1:0]                    o_wr_pulse,
  input  logic                                 i_frame_sync,
  output logic                                 o_commit,
  output logic                                 o_pending
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int ADDRLSB = addr_lsb(DW);
  localparam int IW = AW - ADDRLSB;
  logic aw_valid, w_valid, ar_valid, wr_accept, rd_accept, rd_hit;
  logic commit_d, commit_q, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [DW+SW-1:0] w_beat;
  logic [DW-1:0] wdata, rd_val, rdata_q, rdata_d;
  logic [SW-1:0] wstrb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [N_REGS-1:0] hit, pend;
  logic [N_REGS-1:0][DW-1:0] rd_vals;
  logic unused_ok;
  axil_regbank_skid #(.W(AW)) u_aw (
    .clk(S_AXI_ACLK), .rst(i_reset), .i_valid(s_axi.awvalid), .o_ready(s_axi.awready),
    .i_data(s_axi.awaddr), .o_valid(aw_valid), .i_ready(wr_accept), .o_data(aw_addr)
  );
  axil_regbank_skid #(.W(DW+SW)) u_w (
    .clk(S_AXI_ACLK), .rst(i_reset), .i_valid(s_axi.wvalid), .o_ready(s_axi.wready),
    .i_data({s_axi.wstrb, s_axi.wdata}), .o_valid(w_valid), .i_ready(wr_accept), .o_data(w_beat)
  );
  axil_regbank_skid #(.W(AW)) u_ar (
    .clk(S_AXI_ACLK), .rst(i_reset), .i_valid(s_axi.arvalid), .o_ready(s_axi.arready),
    .i_data(s_axi.araddr), .o_valid(ar_valid), .i_ready(rd_accept), .o_data(ar_addr)
  );
  assign wdata = w_beat[DW-1:0];
  assign wstrb = w_beat[DW+SW-1:DW];
  assign wr_idx = aw_addr[AW-1:ADDRLSB];
  assign rd_idx = ar_addr[AW-1:ADDRLSB];
  assign wr_accept = aw_valid && w_valid && (!bvalid_q || s_axi.bready);
  assign rd_accept = ar_valid && (!rvalid_q || s_axi.rready);
  assign commit_d = i_frame_sync && |pend;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, aw_addr, ar_addr, i_status};
  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    localparam reg_kind_e K = reg_kind(RO_MASK[i], SHADOW_MASK[i]);
    localparam logic [DW-1:0] RV = RESET_VALUES[i*DW +: DW];
    logic [DW-1:0] live_q, live_d, shad_q, shad_d;
    logic pend_q, pend_d, pulse_q, pulse_d, wr_rw, wr_sh;
    assign hit[i] = wr_accept && wr_idx == IW'(i) && K != REG_RO;
    assign wr_rw = hit[i] && K == REG_RW;
    assign wr_sh = hit[i] && K == REG_SHADOW;
    // plain writes land live at once; shadow writes park until a frame commit, which uses the pre-write shadow
    always_comb begin
      live_d = wr_rw ? DW'(apply_wstrb(64'(live_q), 64'(wdata), 8'(wstrb))) : ((commit_d && pend_q) ? shad_q : live_q);
      shad_d = wr_sh ? DW'(apply_wstrb(64'(shad_q), 64'(wdata), 8'(wstrb))) : shad_q;
      pend_d = wr_sh || (pend_q && !commit_d);
      pulse_d = wr_rw || (commit_d && pend_q);
    end
    // per-register storage
    always_ff @(posedge S_AXI_ACLK or posedge i_reset)
      if (i_reset) begin
        live_q <= RV;
        shad_q <= RV;
        pend_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        live_q <= live_d;
        shad_q <= shad_d;
        pend_q <= pend_d;
        pulse_q <= pulse_d;
      end
    assign o_ctrl[i*DW +: DW] = live_q;
    assign o_wr_pulse[i] = pulse_q;
    assign pend[i] = pend_q;
    assign rd_vals[i] = (K == REG_RO) ? i_status[i*DW +: DW] : live_q;
  end
  // read mux: unmapped indices return zero and flag a miss
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    for (int k = 0; k < N_REGS; k++) begin
      rd_val = (rd_idx == IW'(k)) ? rd_vals[k] : rd_val;
      rd_hit = rd_hit || rd_idx == IW'(k);
    end
  end
  // response channel next state: hold each response until the master takes it
  always_comb begin
    bvalid_d = wr_accept || (bvalid_q && !s_axi.bready);
    bresp_d = wr_accept ? (|hit ? RESP_OKAY : RESP_SLVERR) : bresp_q;
    rvalid_d = rd_accept || (rvalid_q && !s_axi.rready);
    rresp_d = rd_accept ? (rd_hit ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    rdata_d = rd_accept ? rd_val : ((OPT_LOWPOWER && !rvalid_d) ? '0 : rdata_q);
  end
  // response and commit registers
  always_ff @(posedge S_AXI_ACLK or posedge i_reset)
    if (i_reset) begin
      bvalid_q <= 1'b0;
      bresp_q <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      commit_q <= 1'b0;
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      commit_q <= commit_d;
    end
  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rdata = rdata_q;
  assign o_commit = commit_q;
  assign o_pending = |pend;
endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: directed self-checking bench for the AXI4-Lite register bank
module tb_axil_regbank;
  localparam logic [255:0] RV_ALL = {32'h0, 32'h0, 32'h0, 32'h0, 32'd8, 32'd64, 32'd64, 32'd2};
  localparam logic [255:0] MID_ALL = {32'h0, 32'h0, 32'h0, 32'h0, 32'd8, 32'd77, 32'd64, 32'h1234_5678};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsync = 1'b0;
  logic [255:0] ctrl, status;
  logic [7:0] pulse;
  logic commit, pending;
  int checks = 0;
  int failures = 0;
  axil_regbank_if #(.AW(6), .DW(32)) bus ();
  axil_regbank #(
    .C_AXI_ADDR_WIDTH(6), .C_AXI_DATA_WIDTH(32), .N_REGS(8), .RESET_VALUES(RV_ALL),
    .RO_MASK(8'h20), .SHADOW_MASK(8'h04), .OPT_LOWPOWER(1'b1)
  ) dut (
    .S_AXI_ACLK(clk), .i_reset(rst), .s_axi(bus), .o_ctrl(ctrl), .i_status(status),
    .o_wr_pulse(pulse), .i_frame_sync(fsync), .o_commit(commit), .o_pending(pending)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp, output logic [7:0] p);
    bus.awvalid = 1'b1; bus.awaddr = a; bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("bvalid_rise", bus.bvalid, 1'b1);
    resp = bus.bresp;
    p = pulse;
    tick();
    chk("bvalid_drop", bus.bvalid, 1'b0);
  endtask
  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_rise", bus.rvalid, 1'b1);
    d = bus.rdata;
    resp = bus.rresp;
    tick();
    chk("rdata_idle_zero", {bus.rvalid, bus.rdata}, 33'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time budget exhausted");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] d;
    logic [1:0] r;
    logic [7:0] p;
    logic [31:0] vals [3];
    logic [31:0] rgot [2];
    logic hs_w, hs_b, hs_a, hs_r;
    int sent, bcnt, rsent, rcnt, pcnt;
    status = {8{32'h1111_1111}};
    status[5*32 +: 32] = 32'h0000_DEAD;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    repeat (2) tick();
    chk("rst_quiet", {bus.bvalid, bus.rvalid, commit, pending, pulse}, 12'h0);
    chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ctrl", ctrl, RV_ALL);
    rst = 1'b0;
    tick();
    rd(6'h04, d, r); chk("rd_reg1", {r, d}, {2'b00, 32'd64});
    rd(6'h0C, d, r); chk("rd_reg3", {r, d}, {2'b00, 32'd8});
    rd(6'h00, d, r); chk("rd_reg0", {r, d}, {2'b00, 32'd2});
    wr(6'h00, 32'h0000_00A5, 4'b0001, r, p);
    chk("wr_a5_resp_pulse", {r, p}, {2'b00, 8'h01});
    chk("wr_a5_val", ctrl[31:0], 32'h0000_00A5);
    wr(6'h00, 32'h1122_3344, 4'b0100, r, p);
    chk("wr_lane2", ctrl[31:0], 32'h0022_00A5);
    wr(6'h00, 32'hFFFF_FFFF, 4'b0000, r, p);
    chk("wr_nostrb_resp_pulse", {r, p}, {2'b00, 8'h01});
    chk("wr_nostrb_val", ctrl[31:0], 32'h0022_00A5);
    wr(6'h08, 32'd128, 4'hF, r, p);
    chk("sh_wr_resp_pulse", {r, p}, {2'b00, 8'h00});
    chk("sh_live_kept", {pending, ctrl[95:64]}, {1'b1, 32'd64});
    fsync = 1'b1; tick(); fsync = 1'b0;
    chk("sh_commit", {commit, pending, pulse, ctrl[95:64]}, {1'b1, 1'b0, 8'h04, 32'd128});
    tick();
    chk("sh_commit_onecycle", {commit, pulse}, 9'h0);
    fsync = 1'b1; tick(); fsync = 1'b0;
    chk("idle_sync", {commit, pulse, pending}, 10'h0);
    wr(6'h08, 32'd32, 4'hF, r, p);
    chk("sh_pend32", {pending, ctrl[95:64]}, {1'b1, 32'd128});
    bus.awvalid = 1'b1; bus.awaddr = 6'h08; bus.wvalid = 1'b1; bus.wdata = 32'd77; bus.wstrb = 4'hF; bus.bready = 1'b1;
    fsync = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; fsync = 1'b0;
    chk("coll_commit", {commit, pending, pulse, ctrl[95:64]}, {1'b1, 1'b1, 8'h04, 32'd32});
    chk("coll_bresp", {bus.bvalid, bus.bresp}, 3'b100);
    tick();
    chk("coll_still_pending", {pending, ctrl[95:64]}, {1'b1, 32'd32});
    fsync = 1'b1; tick(); fsync = 1'b0;
    chk("coll_second_commit", {commit, pending, ctrl[95:64]}, {1'b1, 1'b0, 32'd77});
    bus.awvalid = 1'b1; bus.awaddr = 6'h00; bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 6'h00; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("rw_same_prewrite", {bus.rvalid, bus.rdata}, {1'b1, 32'h0022_00A5});
    chk("rw_same_newval", ctrl[31:0], 32'h1234_5678);
    tick();
    rd(6'h14, d, r); chk("ro_read", {r, d}, {2'b00, 32'h0000_DEAD});
    wr(6'h14, 32'h1, 4'hF, r, p);
    chk("ro_write", {r, p}, {2'b10, 8'h00});
    wr(6'h24, 32'hFFFF_FFFF, 4'hF, r, p);
    chk("oob_write", {r, p}, {2'b10, 8'h00});
    chk("no_side_effects", ctrl, MID_ALL);
    rd(6'h24, d, r); chk("oob_read", {r, d}, {2'b10, 32'h0});
    vals = '{32'h11, 32'h22, 32'h33};
    sent = 0; bcnt = 0; rsent = 0; rcnt = 0; pcnt = 0;
    for (int c = 0; c < 16; c++) begin
      bus.bready = c >= 6; bus.rready = c >= 6;
      bus.awvalid = sent < 3; bus.wvalid = sent < 3; bus.awaddr = 6'h00; bus.wstrb = 4'hF;
      bus.wdata = sent < 3 ? vals[sent] : 32'h0;
      bus.arvalid = rsent < 2; bus.araddr = rsent == 0 ? 6'h04 : 6'h0C;
      hs_w = bus.awvalid && bus.awready && bus.wready;
      hs_b = bus.bvalid && bus.bready;
      hs_a = bus.arvalid && bus.arready;
      hs_r = bus.rvalid && bus.rready;
      if (hs_r && rcnt < 2) rgot[rcnt] = bus.rdata;
      tick();
      sent += int'(hs_w); bcnt += int'(hs_b); rsent += int'(hs_a); rcnt += int'(hs_r);
      pcnt += int'(pulse[0]);
      if (c < 5) begin
        chk("bp_valids_held", {bus.bvalid, bus.rvalid}, 2'b11);
        chk("bp_reg0_stall", ctrl[31:0], 32'h11);
      end
    end
    chk("bp_counts", {sent[3:0], bcnt[3:0], rsent[3:0], rcnt[3:0], pcnt[3:0]}, {4'd3, 4'd3, 4'd2, 4'd2, 4'd3});
    chk("bp_rdata", {rgot[0], rgot[1]}, {32'd64, 32'd8});
    chk("bp_reg0_final", {bus.bvalid, bus.rvalid, ctrl[31:0]}, {2'b00, 32'h33});
    wr(6'h08, 32'd99, 4'hF, r, p);
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 6'h00; bus.wvalid = 1'b1; bus.wdata = 32'h55; bus.arvalid = 1'b1; bus.araddr = 6'h04;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("pre_reset_busy", {bus.bvalid, bus.rvalid, pending, ctrl[31:0]}, {3'b111, 32'h55});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_quiet", {bus.bvalid, bus.rvalid, commit, pending, pulse}, 12'h0);
    chk("async_rst_ctrl", ctrl, RV_ALL);
    tick();
    rst = 1'b0; bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    rd(6'h00, d, r); chk("post_rst_reg0", {r, d}, {2'b00, 32'd2});
    rd(6'h08, d, r); chk("post_rst_reg2", {r, d}, {2'b00, 32'd64});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
